tc_pl_cap_seq: RTL

TC_PL_CAP_SEQ -- requirements
Module: tc_pl_cap_seq

---
 rtl/tc_pl_cap_seq_if.sv | 37 +++
 rtl/tc_pl_cap_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tc_pl_cap_seq_if.sv
// tc_pl_cap_seq_if: control/handshake bundle for the capture sequencer.
// master = run controller and gain/data agents; slave = the sequencer.
interface tc_pl_cap_seq_if #(
   parameter int GIDX_W = 2,
   parameter int DEL_W  = 32,
   parameter int TIME_W = 32
);
   // run control
   logic              cap_trig;
   logic              cap_abort;
   logic              cap_loop;
   logic [GIDX_W:0]   gain_number;
   logic [DEL_W-1:0]  gain_del;
   // completion returns from the gain and data agents
   logic              gain_cmpt;
   logic              data_cmpt;
   // status
   logic              cap_cing;
   logic              cap_cmpt;
   logic              cap_err;
   logic [TIME_W-1:0] cap_time;
   logic [15:0]       cap_pass;
   // stage requests
   logic [GIDX_W-1:0] gain_value;
   logic              gain_en;
   logic              data_en;

   modport master (
      output cap_trig, cap_abort, cap_loop, gain_number, gain_del, gain_cmpt, data_cmpt,
      input  cap_cing, cap_cmpt, cap_err, cap_time, cap_pass, gain_value, gain_en, data_en
   );

   modport slave (
      input  cap_trig, cap_abort, cap_loop, gain_number, gain_del, gain_cmpt, data_cmpt,
      output cap_cing, cap_cmpt, cap_err, cap_time, cap_pass, gain_value, gain_en, data_en
   );
endinterface

// File: rtl/tc_pl_cap_seq.sv
// tc_pl_cap_seq: multi-stage gain/capture sequencer.
// Each stage: request gain setting, wait for its completion, settle for
// gain_del cycles, request data capture, wait for its completion. Runs the
// latched number of stages, optionally repeating passes while cap_loop holds.
// Optional build macro CAP_SEQ_TIMEOUT_EN adds a TO_CYC-cycle handshake
// timeout in GAIN and DATA; without it those states wait indefinitely.
module tc_pl_cap_seq #(
   parameter int GAIN_N = 4,
   parameter int GIDX_W = 2,
   parameter int DEL_W  = 32,
   parameter int TIME_W = 32,
   parameter int TO_CYC = 65535
) (
   input  logic             clk125,
   input  logic             rst,
   tc_pl_cap_seq_if.slave   bus
);

   // reject configurations the stage index cannot represent
   localparam bit CFG_OK = (GAIN_N >= 1) && (GAIN_N <= 8) &&
                           ((1 << GIDX_W) >= GAIN_N) && (TO_CYC >= 1);
   if (!CFG_OK) begin : g_cfg_chk
      $error("tc_pl_cap_seq: invalid GAIN_N/GIDX_W/TO_CYC");
   end

   localparam logic [GIDX_W:0] GN = (GIDX_W+1)'(GAIN_N);

   typedef enum logic [2:0] {IDLE, GAIN, SETTLE, DATA, NEXT, DONE} state_t;

   state_t            state;
   logic [GIDX_W:0]   num_q;
   logic              loop_q;
   logic [DEL_W-1:0]  del_q;
   logic [DEL_W-1:0]  settle_cnt;
   logic [GIDX_W:0]   num_clamp;
   logic [GIDX_W:0]   gv_inc;

   // stage count requested at trigger, limited to the supported stages
   always_comb begin
      num_clamp = bus.gain_number;
      if (bus.gain_number > GN) num_clamp = GN;
   end

   assign gv_inc = {1'b0, bus.gain_value} + (GIDX_W+1)'(1);

`ifdef CAP_SEQ_TIMEOUT_EN
   localparam int WC_W = $clog2(TO_CYC + 1);
   logic [WC_W-1:0] wait_cnt;
   logic            wait_hit;

   assign wait_hit = (wait_cnt == WC_W'(TO_CYC - 1));

   // cycles spent waiting in GAIN/DATA; zero whenever the state is (re)entered
   always_ff @(posedge clk125 or negedge rst) begin
      if (!rst)
         wait_cnt <= '0;
      else if ((state == GAIN && !bus.gain_cmpt) || (state == DATA && !bus.data_cmpt))
         wait_cnt <= wait_cnt + WC_W'(1);
      else
         wait_cnt <= '0;
   end
`endif

   // sequencer FSM with registered status and request pulses
   always_ff @(posedge clk125 or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         num_q          <= '0;
         loop_q         <= 1'b0;
         del_q          <= '0;
         settle_cnt     <= '0;
         bus.cap_cing   <= 1'b0;
         bus.cap_cmpt   <= 1'b0;
         bus.cap_err    <= 1'b0;
         bus.cap_time   <= '0;
         bus.cap_pass   <= '0;
         bus.gain_value <= '0;
         bus.gain_en    <= 1'b0;
         bus.data_en    <= 1'b0;
      end else begin
         bus.gain_en  <= 1'b0;
         bus.data_en  <= 1'b0;
         bus.cap_cmpt <= 1'b0;
         if (bus.cap_cing && bus.cap_time != '1)
            bus.cap_time <= bus.cap_time + TIME_W'(1);

         // abort wins over any completion input; DONE itself always finishes
         if (state != IDLE && state != DONE && bus.cap_abort) begin
            state        <= DONE;
            bus.cap_err  <= 1'b1;
            bus.cap_cmpt <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.cap_trig && !bus.cap_abort) begin
                     num_q          <= num_clamp;
                     loop_q         <= bus.cap_loop;
                     del_q          <= bus.gain_del;
                     bus.cap_err    <= 1'b0;
                     bus.cap_time   <= '0;
                     bus.cap_pass   <= '0;
                     bus.gain_value <= '0;
                     bus.cap_cing   <= 1'b1;
                     if (num_clamp == '0) begin
                        state        <= DONE;
                        bus.cap_err  <= 1'b1;
                        bus.cap_cmpt <= 1'b1;
                     end else begin
                        state       <= GAIN;
                        bus.gain_en <= 1'b1;
                     end
                  end
               end
               GAIN: begin
                  if (bus.gain_cmpt) begin
                     if (del_q == '0) begin
                        state       <= DATA;
                        bus.data_en <= 1'b1;
                     end else begin
                        state      <= SETTLE;
                        settle_cnt <= del_q - DEL_W'(1);
                     end
                  end
`ifdef CAP_SEQ_TIMEOUT_EN
                  else if (wait_hit) begin
                     state        <= DONE;
                     bus.cap_err  <= 1'b1;
                     bus.cap_cmpt <= 1'b1;
                  end
`endif
               end
               SETTLE: begin
                  if (settle_cnt == '0) begin
                     state       <= DATA;
                     bus.data_en <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt - DEL_W'(1);
                  end
               end
               DATA: begin
                  if (bus.data_cmpt)
                     state <= NEXT;
`ifdef CAP_SEQ_TIMEOUT_EN
                  else if (wait_hit) begin
                     state        <= DONE;
                     bus.cap_err  <= 1'b1;
                     bus.cap_cmpt <= 1'b1;
                  end
`endif
               end
               NEXT: begin
                  if (gv_inc < num_q) begin
                     bus.gain_value <= bus.gain_value + GIDX_W'(1);
                     state          <= GAIN;
                     bus.gain_en    <= 1'b1;
                  end else if (loop_q && bus.cap_loop) begin
                     bus.cap_pass   <= bus.cap_pass + 16'd1;
                     bus.gain_value <= '0;
                     state          <= GAIN;
                     bus.gain_en    <= 1'b1;
                  end else begin
                     state        <= DONE;
                     bus.cap_cmpt <= 1'b1;
                  end
               end
               DONE: begin
                  state        <= IDLE;
                  bus.cap_cing <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
